// File: rtl/softex_slot_table_pkg.sv
// Shared types and constants for the SoftEx slot table.
package softex_slot_table_pkg;

    localparam int SLOT_TABLE_N_SLOTS = 8;
    localparam int SLOT_TAG_W         = 8;
    localparam int SLOT_MAX_W         = 16;
    localparam int SLOT_DEN_W         = 32;

    // -inf in FP16ALT, the neutral start value for a running maximum
    localparam logic [SLOT_MAX_W-1:0] SLOT_INIT_MAX = 16'hFF80;

    typedef enum logic {
        SLOT_REQ_LOAD  = 1'b0,
        SLOT_REQ_ALLOC = 1'b1
    } slot_req_op_e;

    typedef enum logic {
        SLOT_UPD_UPDATE = 1'b0,
        SLOT_UPD_FREE   = 1'b1
    } slot_update_op_e;

    typedef struct packed {
        logic                  hit;
        logic                  full;
        logic [SLOT_MAX_W-1:0] maximum;
        logic [SLOT_DEN_W-1:0] denominator;
    } slot_resp_t;

endpackage

// File: rtl/softex_slot_table_if.sv
// Request/response/update bundle between the SoftEx controller and the slot table.
import softex_slot_table_pkg::*;

interface softex_slot_table_if;
    logic                  req_valid_i;
    logic                  req_ready_o;
    slot_req_op_e          req_op_i;
    logic [SLOT_TAG_W-1:0] req_tag_i;

    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic                  resp_hit_o;
    logic                  resp_full_o;
    logic [SLOT_MAX_W-1:0] resp_max_o;
    logic [SLOT_DEN_W-1:0] resp_den_o;

    logic                  upd_valid_i;
    slot_update_op_e       upd_op_i;
    logic [SLOT_TAG_W-1:0] upd_tag_i;
    logic [SLOT_MAX_W-1:0] upd_max_i;
    logic [SLOT_DEN_W-1:0] upd_den_i;

    modport slave (
        input  req_valid_i, req_op_i, req_tag_i, resp_ready_i,
               upd_valid_i, upd_op_i, upd_tag_i, upd_max_i, upd_den_i,
        output req_ready_o, resp_valid_o, resp_hit_o, resp_full_o,
               resp_max_o, resp_den_o
    );

    modport master (
        output req_valid_i, req_op_i, req_tag_i, resp_ready_i,
               upd_valid_i, upd_op_i, upd_tag_i, upd_max_i, upd_den_i,
        input  req_ready_o, resp_valid_o, resp_hit_o, resp_full_o,
               resp_max_o, resp_den_o
    );
endinterface

// File: rtl/softex_slot_table_cam.sv
// Tag match and free-entry selection for the slot table (purely combinational).
import softex_slot_table_pkg::*;

module softex_slot_cam #(
    parameter int N_SLOTS = SLOT_TABLE_N_SLOTS
) (
    input  logic [N_SLOTS-1:0]    valid_i,
    input  logic [SLOT_TAG_W-1:0] tags_i [N_SLOTS],
    input  logic [SLOT_TAG_W-1:0] req_tag_i,
    input  logic [SLOT_TAG_W-1:0] upd_tag_i,
    input  logic                  upd_fire_i,
    input  logic                  upd_free_i,
    output logic [N_SLOTS-1:0]    upd_match_o,
    output logic                  upd_hit_o,
    output logic [N_SLOTS-1:0]    valid_post_o,
    output logic [N_SLOTS-1:0]    req_match_o,
    output logic                  req_hit_o,
    output logic [N_SLOTS-1:0]    free_onehot_o,
    output logic                  free_any_o
);

    // Update port matches against the pre-update state; the request port sees
    // the table after a same-cycle FREE, so freed entries can be re-allocated.
    always_comb begin
        upd_match_o   = '0;
        req_match_o   = '0;
        free_onehot_o = '0;
        free_any_o    = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            upd_match_o[i] = upd_fire_i && valid_i[i] && (tags_i[i] == upd_tag_i);
        end
        upd_hit_o    = |upd_match_o;
        valid_post_o = valid_i & ~(upd_free_i ? upd_match_o : '0);
        for (int i = 0; i < N_SLOTS; i++) begin
            req_match_o[i] = valid_post_o[i] && (tags_i[i] == req_tag_i);
        end
        req_hit_o = |req_match_o;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!valid_post_o[i] && !free_any_o) begin
                free_onehot_o[i] = 1'b1;
                free_any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/softex_slot_table.sv
// Fully associative table of per-row softmax partial state (max, denominator).
import softex_slot_table_pkg::*;

module softex_slot_table #(
    parameter int N_SLOTS = SLOT_TABLE_N_SLOTS,
    localparam int OCC_W  = $clog2(N_SLOTS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    softex_slot_table_if.slave  bus,
    output logic                upd_err_o,
    output logic [OCC_W-1:0]    occupancy_o,
    output logic                full_o
);

    logic [N_SLOTS-1:0]    valid_q, valid_d;
    logic [SLOT_TAG_W-1:0] tag_q [N_SLOTS];
    logic [SLOT_TAG_W-1:0] tag_d [N_SLOTS];
    logic [SLOT_MAX_W-1:0] max_q [N_SLOTS];
    logic [SLOT_MAX_W-1:0] max_d [N_SLOTS];
    logic [SLOT_DEN_W-1:0] den_q [N_SLOTS];
    logic [SLOT_DEN_W-1:0] den_d [N_SLOTS];
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  resp_valid_q, resp_valid_d;
    slot_resp_t            resp_q, resp_d;
    logic                  upd_err_q, upd_err_d;

    logic                  req_fire, upd_fire, upd_free, upd_hit, req_hit, free_any;
    logic                  alloc_new, free_hit;
    logic [N_SLOTS-1:0]    upd_match, upd_wr, valid_post, req_match, free_onehot;
    logic [SLOT_MAX_W-1:0] sel_max;
    logic [SLOT_DEN_W-1:0] sel_den;

    assign bus.req_ready_o = !resp_valid_q || bus.resp_ready_i;
    assign req_fire        = bus.req_valid_i && bus.req_ready_o;
    assign upd_fire        = bus.upd_valid_i;
    assign upd_free        = (bus.upd_op_i == SLOT_UPD_FREE);

    softex_slot_cam #(.N_SLOTS(N_SLOTS)) u_cam (
        .valid_i       (valid_q),
        .tags_i        (tag_q),
        .req_tag_i     (bus.req_tag_i),
        .upd_tag_i     (bus.upd_tag_i),
        .upd_fire_i    (upd_fire),
        .upd_free_i    (upd_free),
        .upd_match_o   (upd_match),
        .upd_hit_o     (upd_hit),
        .valid_post_o  (valid_post),
        .req_match_o   (req_match),
        .req_hit_o     (req_hit),
        .free_onehot_o (free_onehot),
        .free_any_o    (free_any)
    );

    assign upd_wr    = upd_free ? '0 : upd_match;
    assign free_hit  = upd_free && upd_hit;
    assign alloc_new = req_fire && (bus.req_op_i == SLOT_REQ_ALLOC) && !req_hit && free_any;

    // Next table, occupancy and response state; updates land before the lookup.
    always_comb begin
        valid_d      = valid_post;
        tag_d        = tag_q;
        max_d        = max_q;
        den_d        = den_q;
        occ_d        = occ_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        upd_err_d    = upd_fire && !upd_hit;
        sel_max      = '0;
        sel_den      = '0;

        for (int i = 0; i < N_SLOTS; i++) begin
            if (req_match[i]) begin
                sel_max = sel_max | (upd_wr[i] ? bus.upd_max_i : max_q[i]);
                sel_den = sel_den | (upd_wr[i] ? bus.upd_den_i : den_q[i]);
            end
            if (upd_wr[i]) begin
                max_d[i] = bus.upd_max_i;
                den_d[i] = bus.upd_den_i;
            end
            if (alloc_new && free_onehot[i]) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = bus.req_tag_i;
                max_d[i]   = SLOT_INIT_MAX;
                den_d[i]   = '0;
            end
        end

        case ({alloc_new, free_hit})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (req_fire) begin
            resp_valid_d       = 1'b1;
            resp_d.hit         = req_hit;
            resp_d.full        = (bus.req_op_i == SLOT_REQ_ALLOC) && !req_hit && !free_any;
            resp_d.maximum     = req_hit ? sel_max : (alloc_new ? SLOT_INIT_MAX : '0);
            resp_d.denominator = req_hit ? sel_den : '0;
        end else if (bus.resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset and clear both flush the table and drop any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_q      <= '0;
            occ_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            upd_err_q    <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                tag_q[i] <= '0;
                max_q[i] <= '0;
                den_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            upd_err_q    <= upd_err_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                tag_q[i] <= tag_d[i];
                max_q[i] <= max_d[i];
                den_q[i] <= den_d[i];
            end
        end
    end

    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_hit_o   = resp_q.hit;
    assign bus.resp_full_o  = resp_q.full;
    assign bus.resp_max_o   = resp_q.maximum;
    assign bus.resp_den_o   = resp_q.denominator;
    assign upd_err_o        = upd_err_q;
    assign occupancy_o      = occ_q;
    assign full_o           = (occ_q == OCC_W'(N_SLOTS));

endmodule
